uvma_axis_fifo: RTL and testbench
=================================

// Module: uvma_axis_fifo
// PURPOSE
//  AXI-Stream buffering stage that drives the stream bus watched by the AXIS interface checker.
//  - Slave side accepts beats (tdata/tkeep/tlast) from a producer.
//  - Master side replays them in order to the downstream consumer, whose bus the checker observes.
//  - Decouples producer and consumer backpressure with DEPTH entries of storage.
// PARAMETERS
//  DATA_WIDTH  32  tdata width in bits (multiple of 8); tkeep width = DATA_WIDTH/8
//  DEPTH       8   storage entries; power of two, >= 2
// PORTS
//  clk        in   1               single clock, all logic rising-edge
//  reset_n    in   1               asynchronous assert, active-low reset
//  s_tvalid   in   1               producer beat valid
//  s_tready   out  1               FIFO can accept a beat
//  s_tdata    in   DATA_WIDTH      producer data
//  s_tkeep    in   DATA_WIDTH/8    producer byte enables
//  s_tlast    in   1               producer end of packet
//  m_tvalid   out  1               beat available to consumer
//  m_tready   in   1               consumer accepts beat
//  m_tdata    out  DATA_WIDTH      head-of-FIFO data
//  m_tkeep    out  DATA_WIDTH/8    head-of-FIFO byte enables
//  m_tlast    out  1               head-of-FIFO end of packet
//  level      out  $clog2(DEPTH)+1 number of stored beats, 0..DEPTH
//  pkt_count  out  $clog2(DEPTH)+1 complete packets stored (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0, async): level=0, wr/rd pointers=0, m_tvalid=0, s_tready=0, pkt_count=0.
//  - s_tready goes 1 on the first clk edge after reset_n deasserts.
//  - Storage contents are not reset; m_tdata/m_tkeep/m_tlast are don't-care while m_tvalid=0.
//  - push = s_tvalid & s_tready; pop = m_tvalid & m_tready.
//  - Ring-buffer pointers of $clog2(DEPTH) bits wrap DEPTH-1 -> 0 silently.
//  - level counts +1 on push only, -1 on pop only, and is unchanged on push & pop.
//  - All outputs are registered.
//  - s_tready = (level < DEPTH), from the registered level. When full, s_tready is 0 and a push is impossible.
//  - m_tvalid = (level != 0). Latency: a beat pushed at edge N is presented on m_* after edge N with m_tvalid=1.
//    Minimum fall-through latency is 1 cycle.
//  - Simultaneous push & pop when full: illegal, because s_tready=0. The pop makes s_tready=1 after the next edge.
//  - Simultaneous push & pop when level=1: the popped beat leaves, the new beat becomes the head, and level stays 1.
//  - AXIS rules, master side:
//    - once m_tvalid=1 it holds until pop;
//    - m_tdata/m_tkeep/m_tlast are stable while m_tvalid & !m_tready.
//  - AXIS rules, slave side: s_tready may drop only when level reaches DEPTH.
//    It never depends combinationally on s_tvalid.
//  - Full throughput: 1 beat/cycle sustained when both sides are continuously ready.
//  - Beats are forwarded unmodified. tkeep=0 beats and tlast on any beat are carried as-is; no packet framing is enforced.
//  - Reset mid-operation: all stored beats are discarded at once; m_tvalid drops asynchronously with reset_n.
// CONFIGURATION
//  Macro UVMA_AXIS_FIFO_PKT_CNT_EN:
//  - Defined: pkt_count tracks stored beats with tlast=1.
//    - +1 on push with s_tlast, -1 on pop with m_tlast, unchanged when both occur.
//    - Range 0..DEPTH.
//  - Undefined: the pkt_count port remains but is tied to 0; no counter logic is built.
// TESTING
//  1. Reset: hold reset_n=0 for 3 clk -> m_tvalid=0, s_tready=0, level=0, pkt_count=0.
//     Release -> s_tready=1 after 1 edge.
//  2. Single beat, m_tready=1: push tdata=0xA5A5_0001, tkeep=0xF, tlast=1 at edge N.
//     -> m_tvalid=1 with those values after edge N; popped at N+1; level returns to 0.
//  3. Fill and overflow: m_tready=0, s_tvalid=1 for 10 beats (DEPTH=8).
//     -> exactly 8 accepted, s_tready=0, level=8.
//     -> then m_tready=1 drains 0..7 in order.
//  4. Streaming with random m_tready backpressure, 1000 beats: every beat is delivered in order.
//     m_* is stable while stalled (checker assertions pass).
//     Full-ready phase sustains 1 beat/cycle.
//  5. Wrap: 3 sequential fill/drain rounds of 8 beats with incrementing data.
//     -> pointers wrap and data order is preserved.
//  6. Reset mid-stream at level=5 -> immediate m_tvalid=0, level=0.
//     The next pushed beat is the first one delivered.
//  7. PKT_CNT_EN defined: push 3 packets of 2 beats with m_tready=0 -> pkt_count=3.
//     Pop 1 beat -> pkt_count=3; pop 2nd beat -> 2. Undefined: pkt_count stays 0.

Source files
------------

// File: rtl/uvma_axis_fifo.sv
// AXI-Stream FIFO: DEPTH-entry ring buffer between producer (s_*) and
// consumer (m_*); level/pkt_count report occupancy and stored packets.
// Ports: clk, reset_n (async, active-low); s_tvalid/s_tready/s_tdata/
//   s_tkeep/s_tlast in; m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast out;
//   level and pkt_count occupancy outputs.
// Option: define UVMA_AXIS_FIFO_PKT_CNT_EN to build the tlast counter;
//   otherwise pkt_count is tied to 0.
module uvma_axis_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_tkeep,
  input  logic                       s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_tkeep,
  output logic                       m_tlast,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
  } beat_t;

  beat_t          mem_q [DEPTH];
  beat_t          head;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  logic           s_rdy_q;
  logic           m_vld_q;
  logic           push;
  logic           pop;

  assign push = s_tvalid & s_rdy_q;
  assign pop  = m_vld_q & m_tready;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Handshake flags are derived from the next level so they
  // are registered yet exact on the cycle after each edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      s_rdy_q  <= 1'b0;
      m_vld_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      s_rdy_q <= (level_d < LW'(DEPTH));
      m_vld_q <= (level_d != '0);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: s_tdata,
                           keep: s_tkeep,
                           last: s_tlast};
    end
  end

`ifdef UVMA_AXIS_FIFO_PKT_CNT_EN
  logic [LW-1:0] pkt_q;
  logic [LW-1:0] pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    case ({push & s_tlast, pop & head.last})
      2'b10:   pkt_d = pkt_q + LW'(1);
      2'b01:   pkt_d = pkt_q - LW'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pkt_q <= '0;
    else          pkt_q <= pkt_d;
  end

  assign pkt_count = pkt_q;
`else
  assign pkt_count = '0;
`endif

  assign s_tready = s_rdy_q;
  assign m_tvalid = m_vld_q;
  assign m_tdata  = head.data;
  assign m_tkeep  = head.keep;
  assign m_tlast  = head.last;
  assign level    = level_q;

endmodule

// File: tb/tb_uvma_axis_fifo.sv
// Self-checking bench for uvma_axis_fifo against a queue model.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uvma_axis_fifo;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [3:0]  level, pkt_count;

  uvma_axis_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .level(level), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  beat_t q[$];
  bit    mdl_run;
  int    n_assert = 0;
  int    n_fail   = 0;
  int    dut_pops = 0;
  string phase    = "init";

  task automatic cmp(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: got %0h expected %0h",
             phase, tag, got, exp);
    end
  endtask

  task automatic chk();
    int pk = 0;
`ifdef UVMA_AXIS_FIFO_PKT_CNT_EN
    foreach (q[i]) if (q[i].l) pk++;
`endif
    cmp("m_tvalid", m_tvalid, q.size() != 0);
    cmp("s_tready", s_tready,
        mdl_run && q.size() < DEPTH);
    cmp("level", level, q.size());
    cmp("pkt_count", pkt_count, pk);
    if (q.size() != 0) begin
      cmp("m_tdata", m_tdata, q[0].d);
      cmp("m_tkeep", m_tkeep, q[0].k);
      cmp("m_tlast", m_tlast, q[0].l);
    end
  endtask

  task automatic step(input logic sv, input beat_t b,
                      input logic mr, output logic pushed);
    logic push, pop;
    s_tvalid = sv;
    s_tdata  = b.d;
    s_tkeep  = b.k;
    s_tlast  = b.l;
    m_tready = mr;
    push = sv && mdl_run && q.size() < DEPTH;
    pop  = mr && q.size() != 0;
    if (m_tvalid && m_tready) dut_pops++;
    @(posedge clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(b);
    if (reset_n) mdl_run = 1'b1;
    pushed = push;
    chk();
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    b.d = $urandom;
    b.k = 4'($urandom_range(0, 15));
    b.l = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic beat_t mk(input logic [31:0] d,
                               input logic l);
    beat_t b;
    b.d = d;
    b.k = 4'hF;
    b.l = l;
    return b;
  endfunction

  initial begin
    logic  pd;
    beat_t b;
    int    sent;
    logic  have;
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    mdl_run  = 1'b0;

    phase = "reset";
    #1 chk();
    for (int i = 0; i < 3; i++) step(1'b0, mk(0, 0), 1'b0, pd);
    reset_n = 1'b1;
    #1 chk();
    step(1'b0, mk(0, 0), 1'b0, pd);

    phase = "single";
    step(1'b1, '{d: 32'hA5A5_0001, k: 4'hF, l: 1'b1},
         1'b1, pd);
    cmp("single_valid", m_tvalid, 1'b1);
    step(1'b0, mk(0, 0), 1'b1, pd);
    cmp("single_level", level, 0);

    phase = "fill";
    for (int i = 0; i < 10; i++)
      step(1'b1, mk(i, 0), 1'b0, pd);
    cmp("fill_level", level, 8);
    cmp("fill_ready", s_tready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cmp("drain_order", m_tdata, i);
      step(1'b0, mk(0, 0), 1'b1, pd);
    end

    phase = "random";
    sent = 0;
    have = 1'b0;
    while (sent < 1000) begin
      if (!have) begin
        b = rnd_beat();
        have = 1'b1;
      end
      step(1'b1, b, 1'($urandom_range(0, 1)), pd);
      if (pd) begin
        sent++;
        have = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b0, mk(0, 0), 1'b1, pd);

    phase = "thru";
    dut_pops = 0;
    for (int i = 0; i < 50; i++)
      step(1'b1, rnd_beat(), 1'b1, pd);
    cmp("throughput", dut_pops, 49);
    step(1'b0, mk(0, 0), 1'b1, pd);

    phase = "wrap";
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++)
        step(1'b1, mk(r * 8 + i, i == 7), 1'b0, pd);
      for (int i = 0; i < 8; i++)
        step(1'b0, mk(0, 0), 1'b1, pd);
    end

    phase = "midreset";
    for (int i = 0; i < 5; i++)
      step(1'b1, mk(32'h100 + i, 0), 1'b0, pd);
    cmp("pre_level", level, 5);
    reset_n = 1'b0;
    #1;
    q.delete();
    mdl_run = 1'b0;
    chk();
    step(1'b0, mk(0, 0), 1'b0, pd);
    reset_n = 1'b1;
    step(1'b0, mk(0, 0), 1'b0, pd);
    step(1'b1, mk(32'hBEEF_0042, 1), 1'b0, pd);
    cmp("first_after", m_tdata, 32'hBEEF_0042);
    step(1'b0, mk(0, 0), 1'b1, pd);

    phase = "pkt";
    for (int p = 0; p < 3; p++) begin
      step(1'b1, mk(p * 2, 0), 1'b0, pd);
      step(1'b1, mk(p * 2 + 1, 1), 1'b0, pd);
    end
`ifdef UVMA_AXIS_FIFO_PKT_CNT_EN
    cmp("pkt3", pkt_count, 3);
    step(1'b0, mk(0, 0), 1'b1, pd);
    cmp("pkt_pop1", pkt_count, 3);
    step(1'b0, mk(0, 0), 1'b1, pd);
    cmp("pkt_pop2", pkt_count, 2);
`else
    cmp("pkt3", pkt_count, 0);
    step(1'b0, mk(0, 0), 1'b1, pd);
    step(1'b0, mk(0, 0), 1'b1, pd);
    cmp("pkt_pop2", pkt_count, 0);
`endif
    for (int i = 0; i < 5; i++)
      step(1'b0, mk(0, 0), 1'b1, pd);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
